// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver: framed serial-in / parallel-out receiver with valid/ready output,
// frame restart detection and sticky overrun flag.
module serial_byte_receiver #(
  parameter int WIDTH = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_data,
  input  logic             s_first,
  input  logic             hold,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_ovr
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr, shifted, loaded;
  logic take, restart, advance, done;
  always_comb begin
    take    = s_valid & ~hold;
    restart = take & s_first;
    advance = take & ~s_first & (state == SHIFT);
    done    = advance & (cnt == CW'(WIDTH - 1));
    shifted = (MSB_FIRST != 0) ? {sr[WIDTH-2:0], s_data} : {s_data, sr[WIDTH-1:1]};
    loaded  = (MSB_FIRST != 0) ? {{(WIDTH-1){1'b0}}, s_data} : {s_data, {(WIDTH-1){1'b0}}};
  end
  // The completing word goes straight from the shift path into p_data, so no extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      p_data    <= '0;
      p_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= restart & (state == SHIFT);
      if (restart) begin
        sr    <= loaded;
        cnt   <= CW'(1);
        state <= SHIFT;
      end else if (advance) begin
        sr    <= shifted;
        cnt   <= cnt + CW'(1);
        state <= done ? IDLE : SHIFT;
      end
      if (done && (!p_valid || p_ready)) begin
        p_data  <= shifted;
        p_valid <= 1'b1;
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end
      if (done && p_valid && !p_ready) overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_byte_receiver.sv
// tb_serial_byte_receiver: directed steps with a scoreboard of expected words,
// popped whenever the DUT hands a word over.
module tb_serial_byte_receiver;
  logic clk = 1'b0;
  logic rst_n, s_valid, s_data, s_first, hold, p_ready, clr_ovr;
  logic [7:0] p_data, l_data;
  logic p_valid, frame_err, overrun, l_valid, l_ferr, l_ovr;
  int passed = 0;
  int total = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  serial_byte_receiver #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_first(s_first),
    .hold(hold), .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
    .frame_err(frame_err), .overrun(overrun), .clr_ovr(clr_ovr));

  serial_byte_receiver #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_first(s_first),
    .hold(hold), .p_data(l_data), .p_valid(l_valid), .p_ready(p_ready),
    .frame_err(l_ferr), .overrun(l_ovr), .clr_ovr(clr_ovr));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Inputs change and checks run 2 time units after each rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic d, input logic f);
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    step();
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i], i == 7);
  endtask

  always @(negedge clk) begin
    if (rst_n && p_valid && p_ready) begin
      if (sb.size() == 0) chk("unexpected_word", p_data, 8'hxx);
      else chk("sb_word", p_data, sb.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = 1'b0; s_first = 1'b0;
    hold = 1'b0; p_ready = 1'b1; clr_ovr = 1'b0;
    step(); step();
    chk("rst_p_valid", {7'd0, p_valid}, 8'd0);
    chk("rst_p_data", p_data, 8'h00);
    chk("rst_frame_err", {7'd0, frame_err}, 8'd0);
    chk("rst_overrun", {7'd0, overrun}, 8'd0);
    rst_n = 1'b1;
    step();
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_p_valid", {7'd0, p_valid}, 8'd0);
    chk("midrst_p_data", p_data, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    sb.push_back(8'h5A);
    send_frame(8'h5A);
    chk("fresh_valid", {7'd0, p_valid}, 8'd1);
    step();
    sb.push_back(8'hEE);
    send_frame(8'hEE);
    chk("msb_valid", {7'd0, p_valid}, 8'd1);
    chk("msb_data", p_data, 8'hEE);
    chk("lsb_data", l_data, 8'h77);
    step();
    chk("one_cycle_valid", {7'd0, p_valid}, 8'd0);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    sb.push_back(8'hA5);
    send_bit(1'b1, 1'b1);
    chk("restart_ferr", {7'd0, frame_err}, 8'd1);
    send_bit(1'b0, 1'b0);
    chk("restart_ferr_pulse", {7'd0, frame_err}, 8'd0);
    chk("restart_no_word", {7'd0, p_valid}, 8'd0);
    for (int i = 5; i >= 0; i--) send_bit(8'hA5 >> i & 8'd1, 1'b0);
    chk("restart_valid", {7'd0, p_valid}, 8'd1);
    step();
    p_ready = 1'b0;
    sb.push_back(8'h3C);
    send_frame(8'h3C);
    send_frame(8'hC3);
    chk("ovr_data", p_data, 8'h3C);
    chk("ovr_flag", {7'd0, overrun}, 8'd1);
    chk("ovr_valid", {7'd0, p_valid}, 8'd1);
    step();
    chk("ovr_sticky", {7'd0, overrun}, 8'd1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr_cleared", {7'd0, overrun}, 8'd0);
    p_ready = 1'b1;
    step();
    chk("ovr_drain", {7'd0, p_valid}, 8'd0);
    p_ready = 1'b0;
    sb.push_back(8'h96);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    hold = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = i[0];
      s_first = (i == 1);
      step();
    end
    hold = 1'b0;
    s_valid = 1'b0;
    s_first = 1'b0;
    chk("hold_no_ferr", {7'd0, frame_err}, 8'd0);
    for (int i = 4; i >= 0; i--) send_bit(8'h96 >> i & 8'd1, 1'b0);
    chk("hold_valid", {7'd0, p_valid}, 8'd1);
    chk("hold_data", p_data, 8'h96);
    sb.push_back(8'h69);
    for (int i = 7; i >= 1; i--) send_bit(8'h69 >> i & 8'd1, i == 7);
    p_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    chk("b2b_valid", {7'd0, p_valid}, 8'd1);
    chk("b2b_data", p_data, 8'h69);
    chk("b2b_no_ovr", {7'd0, overrun}, 8'd0);
    step();
    chk("b2b_drain", {7'd0, p_valid}, 8'd0);
    step();
    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
